stream_drain_fifo: RTL and testbench

Receive-side elastic buffer for the no-backpressure valid/data streams produced by the capture pipeline, including the outputs of the fixed-latency delay lines. It accepts one word per clock whenever `validIn` is high and hands the words to a downstream consumer over a valid/ready handshake. Words that arrive while the buffer is full are dropped and counted.

---
 rtl/stream_drain_fifo.sv | 104 ++++++++++
 tb/tb_stream_drain_fifo.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/stream_drain_fifo.sv
// Receive-side elastic buffer for no-backpressure valid/data streams.
// Upstream pushes one word per clock whenever validIn is high; downstream
// drains with a valid/ready handshake. Words arriving while the buffer is
// full (and nothing is leaving that cycle) are discarded, flagged in the
// sticky overflow bit and tallied in a saturating drop counter.
//
// Pointers carry one extra wrap bit so that full and empty are told apart
// without a separate occupancy register; count is derived from them.
module stream_drain_fifo #(
  parameter  int WIDTH = 32,
  parameter  int DEPTH = 16,
  parameter  int AFULL = DEPTH - 2,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             validIn,
  input  logic [WIDTH-1:0] dataIn,
  output logic             validOut,
  output logic [WIDTH-1:0] dataOut,
  input  logic             readyIn,
  output logic [AW:0]      count,
  output logic             almostFull,
  output logic             overflow,
  output logic [15:0]      dropCount,
  input  logic             clearOverflow
);

  localparam logic [AW:0]  AFULL_LVL = (AW + 1)'(AFULL);
  localparam logic [15:0]  DROP_MAX  = 16'hFFFF;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wp;
  logic [AW:0]      rp;

  logic empty;
  logic full;
  logic pop;
  logic push;
  logic drop;

  // Occupancy decode and per-cycle transfer decisions.
  always_comb begin
    empty = (wp == rp);
    full  = (wp[AW-1:0] == rp[AW-1:0]) && (wp[AW] != rp[AW]);
    pop   = !empty && readyIn;
    // A pop in the same cycle frees the slot, so a full buffer still
    // accepts the incoming word instead of dropping it.
    push  = validIn && (!full || pop);
    drop  = validIn && full && !pop;
  end

  // Status outputs: head word is read straight from the array so the
  // storage can map onto distributed RAM with an async read port.
  always_comb begin
    validOut   = !empty;
    dataOut    = mem[rp[AW-1:0]];
    count      = wp - rp;
    almostFull = (count >= AFULL_LVL);
  end

  // Storage write; contents are intentionally left unreset.
  always_ff @(posedge clock) begin
    if (push) begin
      mem[wp[AW-1:0]] <= dataIn;
    end
  end

  // Write pointer; wrap bit toggles naturally on carry out of the index.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      wp <= '0;
    end else if (push) begin
      wp <= wp + 1'b1;
    end
  end

  // Read pointer advances on every accepted handshake.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      rp <= '0;
    end else if (pop) begin
      rp <= rp + 1'b1;
    end
  end

  // Overflow tracking; clear wins over a coincident drop so software sees
  // a clean zero after acknowledging.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      overflow  <= 1'b0;
      dropCount <= '0;
    end else if (clearOverflow) begin
      overflow  <= 1'b0;
      dropCount <= '0;
    end else if (drop) begin
      overflow <= 1'b1;
      if (dropCount != DROP_MAX) begin
        dropCount <= dropCount + 16'd1;
      end
    end
  end

endmodule

// File: tb/tb_stream_drain_fifo.sv
// Directed bench for stream_drain_fifo (WIDTH=32, DEPTH=16, AFULL=14).
module tb_stream_drain_fifo;

  logic        clock;
  logic        reset;
  logic        validIn;
  logic [31:0] dataIn;
  logic        validOut;
  logic [31:0] dataOut;
  logic        readyIn;
  logic [4:0]  count;
  logic        almostFull;
  logic        overflow;
  logic [15:0] dropCount;
  logic        clearOverflow;

  int checks   = 0;
  int failures = 0;

  stream_drain_fifo #(.WIDTH(32), .DEPTH(16), .AFULL(14)) dut (
    .clock         (clock),
    .reset         (reset),
    .validIn       (validIn),
    .dataIn        (dataIn),
    .validOut      (validOut),
    .dataOut       (dataOut),
    .readyIn       (readyIn),
    .count         (count),
    .almostFull    (almostFull),
    .overflow      (overflow),
    .dropCount     (dropCount),
    .clearOverflow (clearOverflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  initial begin
    #5_000_000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Advance one clock; inputs change and outputs are sampled 1 ns after the edge.
  task automatic step();
    @(posedge clock);
    #1;
  endtask

  logic [31:0] q[$];
  int          drops;
  int          exp_cnt;
  logic        rdy;
  logic        mpop;

  initial begin
    reset = 1'b0; validIn = 1'b0; dataIn = '0; readyIn = 1'b0; clearOverflow = 1'b0;
    step(); step();

    // ---- reset state
    chk("rst_validOut", validOut, 0);
    chk("rst_count", count, 0);
    chk("rst_almostFull", almostFull, 0);
    chk("rst_overflow", overflow, 0);
    chk("rst_dropCount", dropCount, 0);
    reset = 1'b1;
    step();

    // ---- single word, no bypass, latency 1
    validIn = 1'b1; dataIn = 32'hDEADBEEF;
    #1;
    chk("nobypass_validOut", validOut, 0);
    step();
    validIn = 1'b0;
    chk("single_validOut", validOut, 1);
    chk("single_dataOut", dataOut, 32'hDEADBEEF);
    chk("single_count", count, 1);
    readyIn = 1'b1;
    step();
    chk("single_pop_validOut", validOut, 0);
    chk("single_pop_count", count, 0);
    step();
    chk("ready_when_empty_count", count, 0);
    readyIn = 1'b0;

    // ---- fill 0..17 with readyIn low
    for (int i = 0; i < 18; i++) begin
      validIn = 1'b1; dataIn = i;
      step();
      exp_cnt = (i + 1 > 16) ? 16 : i + 1;
      chk("fill_count", count, exp_cnt);
      chk("fill_almostFull", almostFull, (exp_cnt >= 14) ? 1 : 0);
      chk("fill_head_stable", dataOut, 0);
    end
    validIn = 1'b0;
    chk("fill_overflow", overflow, 1);
    chk("fill_dropCount", dropCount, 2);
    readyIn = 1'b1;
    for (int i = 0; i < 16; i++) begin
      chk("drain_validOut", validOut, 1);
      chk("drain_dataOut", dataOut, i);
      step();
    end
    chk("drain_empty", validOut, 0);
    chk("drain_count", count, 0);
    readyIn = 1'b0;
    clearOverflow = 1'b1;
    step();
    clearOverflow = 1'b0;
    chk("clear_overflow", overflow, 0);
    chk("clear_dropCount", dropCount, 0);

    // ---- full with simultaneous push/pop
    for (int i = 0; i < 16; i++) begin
      validIn = 1'b1; dataIn = i;
      step();
    end
    chk("full_count", count, 16);
    readyIn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      dataIn = 100 + k;
      chk("pp_dataOut", dataOut, (k < 16) ? k : 100 + k - 16);
      step();
      chk("pp_count", count, 16);
    end
    validIn = 1'b0;
    chk("pp_overflow", overflow, 0);
    chk("pp_dropCount", dropCount, 0);
    for (int k = 4; k < 20; k++) begin
      chk("pp_drain_dataOut", dataOut, 100 + k);
      step();
    end
    chk("pp_drain_empty", validOut, 0);
    readyIn = 1'b0;

    // ---- streaming 1000 words, random readyIn, queue model
    drops = 0;
    for (int n = 0; n < 1000; n++) begin
      rdy = 1'($urandom_range(0, 1));
      readyIn = rdy; validIn = 1'b1; dataIn = 32'h1000 + n;
      #1;
      mpop = (q.size() > 0) && rdy;
      if (mpop) begin
        chk("stream_dataOut", dataOut, q[0]);
        void'(q.pop_front());
      end
      if (q.size() < 16) q.push_back(32'h1000 + n);
      else drops++;
      step();
      chk("stream_count", count, q.size());
    end
    validIn = 1'b0; readyIn = 1'b1;
    for (int k = 0; k < 20; k++) begin
      if (q.size() > 0) begin
        chk("stream_drain_dataOut", dataOut, q[0]);
        void'(q.pop_front());
        step();
      end
    end
    chk("stream_empty", validOut, 0);
    chk("stream_dropCount", dropCount, drops);
    chk("stream_overflow", overflow, (drops > 0) ? 1 : 0);
    readyIn = 1'b0;
    clearOverflow = 1'b1;
    step();
    clearOverflow = 1'b0;

    // ---- clear priority over coincident drop, then saturation
    for (int i = 0; i < 16; i++) begin
      validIn = 1'b1; dataIn = 32'h5000 + i;
      step();
    end
    step();
    chk("cp_pre_overflow", overflow, 1);
    chk("cp_pre_dropCount", dropCount, 1);
    clearOverflow = 1'b1;
    step();
    clearOverflow = 1'b0;
    chk("cp_overflow", overflow, 0);
    chk("cp_dropCount", dropCount, 0);
    for (int i = 0; i < 65535; i++) step();
    chk("sat_dropCount_edge", dropCount, 16'hFFFF);
    for (int i = 0; i < 5; i++) step();
    validIn = 1'b0;
    chk("sat_dropCount", dropCount, 16'hFFFF);
    chk("sat_overflow", overflow, 1);
    chk("sat_count", count, 16);
    chk("sat_head", dataOut, 32'h5000);

    // ---- async reset mid-stream
    clearOverflow = 1'b1; readyIn = 1'b1;
    for (int i = 0; i < 16; i++) step();
    clearOverflow = 1'b0; readyIn = 1'b0;
    chk("ar_pre_empty", validOut, 0);
    for (int i = 0; i < 7; i++) begin
      validIn = 1'b1; dataIn = 32'h7000 + i;
      step();
    end
    validIn = 1'b0;
    chk("ar_pre_count", count, 7);
    #2;
    reset = 1'b0;
    #1;
    chk("ar_validOut", validOut, 0);
    chk("ar_count", count, 0);
    step();
    reset = 1'b1;
    step();
    validIn = 1'b1; dataIn = 32'hCAFEF00D;
    step();
    validIn = 1'b0;
    chk("ar_post_validOut", validOut, 1);
    chk("ar_post_dataOut", dataOut, 32'hCAFEF00D);
    chk("ar_post_count", count, 1);
    readyIn = 1'b1;
    step();
    chk("ar_post_pop", validOut, 0);
    readyIn = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
